// File: rtl/ad574_ctrl_if.sv
// Command interface between the sampling sequencer (master) and ad574_ctrl (slave).
interface ad574_ctrl_if;
    logic        op_req;
    logic        op;
    logic [1:0]  addr;
    logic        busy;
    logic [11:0] rd_data;
    logic        rd_valid;
    logic        conv_done;
    logic        conv_err;

    modport master (
        output op_req, op, addr,
        input  busy, rd_data, rd_valid, conv_done, conv_err
    );

    modport slave (
        input  op_req, op, addr,
        output busy, rd_data, rd_valid, conv_done, conv_err
    );
endinterface

// File: rtl/ad574_ctrl.sv
// AD574 pin-level bus controller: sequences CS/CE/R_C/A0/12_8, tracks STS, returns read data.
// Optional STS timeout in WAIT_STS enabled by defining AD574_STS_TIMEOUT_EN.
module ad574_ctrl #(
    parameter int unsigned T_SETUP   = 2,
    parameter int unsigned T_CE      = 4,
    parameter int unsigned T_HOLD    = 2,
    parameter int unsigned T_STS_DLY = 8,
    parameter int unsigned T_TIMEOUT = 4096
) (
    input  logic         clk,
    input  logic         rstn,
    ad574_ctrl_if.slave  bus,
    output logic         ad_cs_n,
    output logic         ad_ce,
    output logic         ad_rc,
    output logic         ad_a0,
    output logic         ad_12_8,
    input  logic         ad_sts,
    input  logic [11:0]  ad_db
);
    localparam int unsigned MAX_A = (T_SETUP > T_CE) ? T_SETUP : T_CE;
    localparam int unsigned MAX_B = (T_HOLD > T_STS_DLY) ? T_HOLD : T_STS_DLY;
    localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned MAX_P = (MAX_C > T_TIMEOUT) ? MAX_C : T_TIMEOUT;
    localparam int unsigned CW    = $clog2(MAX_P) + 1;
`ifdef AD574_STS_TIMEOUT_EN
    // Counter spans the whole timeout; STS is looked at once the delay part has elapsed.
    localparam int unsigned W_LOAD = T_TIMEOUT - 1;
    localparam int unsigned W_CHK  = T_TIMEOUT - T_STS_DLY;
`else
    localparam int unsigned W_LOAD = T_STS_DLY - 1;
`endif

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT_STS, DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            r_op, w_op_nxt;
    logic            r_sts_m, r_sts_s;
    logic            w_sts_open;
    logic            r_busy, w_busy;
    logic [11:0]     r_rd_data, w_rd_data;
    logic            r_rd_valid, w_rd_valid;
    logic            r_conv_done, w_conv_done;
    logic            r_cs_n, w_cs_n;
    logic            r_ce, w_ce;
    logic            r_rc, w_rc;
    logic            r_a0, w_a0;
    logic            r_12_8, w_12_8;
`ifdef AD574_STS_TIMEOUT_EN
    logic            r_conv_err, w_conv_err;
    assign w_sts_open = (r_cnt <= CW'(W_CHK));
`else
    assign w_sts_open = (r_cnt == '0);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        w_busy      = r_busy;
        w_rd_data   = r_rd_data;
        w_rd_valid  = 1'b0;
        w_conv_done = 1'b0;
        w_cs_n      = r_cs_n;
        w_ce        = r_ce;
        w_rc        = r_rc;
        w_a0        = r_a0;
        w_12_8      = r_12_8;
`ifdef AD574_STS_TIMEOUT_EN
        w_conv_err  = r_conv_err;
`endif
        case (r_state)
            IDLE: begin
                if (bus.op_req) begin
                    w_op_nxt    = bus.op;
                    w_busy      = 1'b1;
                    w_cs_n      = 1'b0;
                    w_rc        = ~bus.op;
                    w_a0        = bus.addr[0];
                    w_12_8      = bus.addr[1];
                    w_cnt_nxt   = CW'(T_SETUP - 1);
                    w_state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (r_cnt == '0) begin
                    w_ce        = 1'b1;
                    w_cnt_nxt   = CW'(T_CE - 1);
                    w_state_nxt = PULSE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            PULSE: begin
                if (r_cnt == '0) begin
                    w_ce = 1'b0;
                    if (!r_op) begin
                        w_rd_data = ad_db;
                    end
                    w_cnt_nxt   = CW'(T_HOLD - 1);
                    w_state_nxt = HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            HOLD: begin
                if (r_cnt == '0) begin
                    w_cs_n  = 1'b1;
                    w_rc    = 1'b1;
                    w_a0    = 1'b0;
                    w_12_8  = 1'b1;
                    if (r_op) begin
                        w_cnt_nxt   = CW'(W_LOAD);
                        w_state_nxt = WAIT_STS;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            WAIT_STS: begin
                if (w_sts_open && !r_sts_s) begin
                    w_state_nxt = DONE;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
`ifdef AD574_STS_TIMEOUT_EN
                else begin
                    w_conv_err  = 1'b1;
                    w_state_nxt = DONE;
                end
`endif
            end
            DONE: begin
                w_busy      = 1'b0;
                w_rd_valid  = ~r_op;
                w_conv_done = r_op;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_op        <= 1'b0;
            r_sts_m     <= 1'b0;
            r_sts_s     <= 1'b0;
            r_busy      <= 1'b0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_conv_done <= 1'b0;
            r_cs_n      <= 1'b1;
            r_ce        <= 1'b0;
            r_rc        <= 1'b1;
            r_a0        <= 1'b0;
            r_12_8      <= 1'b1;
`ifdef AD574_STS_TIMEOUT_EN
            r_conv_err  <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_op        <= w_op_nxt;
            r_sts_m     <= ad_sts;
            r_sts_s     <= r_sts_m;
            r_busy      <= w_busy;
            r_rd_data   <= w_rd_data;
            r_rd_valid  <= w_rd_valid;
            r_conv_done <= w_conv_done;
            r_cs_n      <= w_cs_n;
            r_ce        <= w_ce;
            r_rc        <= w_rc;
            r_a0        <= w_a0;
            r_12_8      <= w_12_8;
`ifdef AD574_STS_TIMEOUT_EN
            r_conv_err  <= w_conv_err;
`endif
        end
    end

    assign bus.busy      = r_busy;
    assign bus.rd_data   = r_rd_data;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.conv_done = r_conv_done;
`ifdef AD574_STS_TIMEOUT_EN
    assign bus.conv_err  = r_conv_err;
`else
    assign bus.conv_err  = 1'b0;
`endif
    assign ad_cs_n = r_cs_n;
    assign ad_ce   = r_ce;
    assign ad_rc   = r_rc;
    assign ad_a0   = r_a0;
    assign ad_12_8 = r_12_8;
endmodule

// File: tb/tb_ad574_ctrl.sv
// Self-checking bench for ad574_ctrl: directed and random commands against a cycle-index model.
module tb_ad574_ctrl;
    localparam int unsigned T_SETUP   = 2;
    localparam int unsigned T_CE      = 4;
    localparam int unsigned T_HOLD    = 2;
    localparam int unsigned T_STS_DLY = 8;
`ifdef AD574_STS_TIMEOUT_EN
    localparam int unsigned T_TIMEOUT = 64;
`else
    localparam int unsigned T_TIMEOUT = 4096;
`endif
    localparam int unsigned L = T_SETUP + T_CE + T_HOLD;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ad_sts = 1'b0;
    logic [11:0] ad_db = '0;
    logic        ad_cs_n, ad_ce, ad_rc, ad_a0, ad_12_8;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          exp_err = 1'b0;

    ad574_ctrl_if bus ();

    ad574_ctrl #(
        .T_SETUP  (T_SETUP),
        .T_CE     (T_CE),
        .T_HOLD   (T_HOLD),
        .T_STS_DLY(T_STS_DLY),
        .T_TIMEOUT(T_TIMEOUT)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .bus    (bus),
        .ad_cs_n(ad_cs_n),
        .ad_ce  (ad_ce),
        .ad_rc  (ad_rc),
        .ad_a0  (ad_a0),
        .ad_12_8(ad_12_8),
        .ad_sts (ad_sts),
        .ad_db  (ad_db)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // {busy, rd_valid, conv_done, cs_n, ce, rc, a0, 12_8} at their inactive levels
    task automatic chk_idle(input string tag);
        chk({tag, " pins"}, 32'({bus.busy, bus.rd_valid, bus.conv_done,
                                 ad_cs_n, ad_ce, ad_rc, ad_a0, ad_12_8}), 32'h15);
        chk({tag, " conv_err"}, 32'(bus.conv_err), 32'(exp_err));
    endtask

    // One command, checked every cycle from the accepting edge (k=0) to one cycle past completion.
    task automatic run_cmd(input logic op, input logic [1:0] addr, input logic [11:0] data,
                           input int unsigned fall_dly, input bit noise,
                           input bit do_rst, input int unsigned rst_k);
        int unsigned done_k;
        int unsigned f_k;
        bit          tmo;
        logic [4:0]  exp_pins;
        tmo = 1'b0;
        f_k = 0;
        if (op) begin
            f_k    = T_SETUP + T_CE + fall_dly;
            done_k = (L + T_STS_DLY + 1 > f_k + 4) ? L + T_STS_DLY + 1 : f_k + 4;
`ifdef AD574_STS_TIMEOUT_EN
            if (done_k > L + T_TIMEOUT + 1) begin
                done_k = L + T_TIMEOUT + 1;
                tmo    = 1'b1;
            end
`endif
        end else begin
            done_k = L + 1;
        end
        @(negedge clk);
        bus.op_req = 1'b1;
        bus.op     = op;
        bus.addr   = addr;
        ad_db      = data ^ 12'($urandom_range(1, 4095));
        for (int unsigned k = 0; k <= done_k + 1; k++) begin
            @(negedge clk);
            exp_pins = {k < done_k, !(k < L), (k >= T_SETUP) && (k < T_SETUP + T_CE),
                        !op && (k == done_k), op && (k == done_k)};
            chk($sformatf("op%0b k=%0d busy/cs_n/ce/rv/cd", op, k),
                32'({bus.busy, ad_cs_n, ad_ce, bus.rd_valid, bus.conv_done}), 32'(exp_pins));
            if (k < L)
                chk($sformatf("op%0b k=%0d rc/a0/12_8", op, k),
                    32'({ad_rc, ad_a0, ad_12_8}), 32'({~op, addr[0], addr[1]}));
            if (!op && k == done_k)
                chk("rd_data", 32'(bus.rd_data), 32'(data));
            if (do_rst && k == rst_k) begin
                bus.op_req = 1'b0;
                rstn       = 1'b0;
                @(negedge clk);
                exp_err = 1'b0;
                chk_idle("rst_mid");
                chk("rst_mid rd_data", 32'(bus.rd_data), 32'h0);
                rstn   = 1'b1;
                ad_sts = 1'b0;
                @(negedge clk);
                chk_idle("after_rst");
                return;
            end
            bus.op_req = 1'b0;
            if (noise && k < done_k && ($urandom_range(3) == 0 || k + 1 == done_k)) begin
                bus.op_req = 1'b1;
                bus.op     = 1'($urandom);
                bus.addr   = 2'($urandom);
            end
            ad_db = (k + 1 == T_SETUP + T_CE) ? data : data ^ 12'($urandom_range(1, 4095));
            if (op && k == T_SETUP) ad_sts = 1'b1;
            if (op && k == f_k)     ad_sts = 1'b0;
        end
        bus.op_req = 1'b0;
        ad_sts     = 1'b0;
        if (tmo) exp_err = 1'b1;
        chk($sformatf("op%0b conv_err", op), 32'(bus.conv_err), 32'(exp_err));
    endtask

    initial begin
        bus.op_req = 1'b0;
        bus.op     = 1'b0;
        bus.addr   = 2'b00;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        chk("reset rd_data", 32'(bus.rd_data), 32'h0);
        rstn = 1'b1;
        @(negedge clk);
        chk_idle("post_reset");

        run_cmd(1'b0, 2'b10, 12'hA5C, 0, 1'b0, 1'b0, 0);
        run_cmd(1'b1, 2'b10, 12'h000, 20, 1'b0, 1'b0, 0);

        for (int unsigned i = 0; i < 24; i++)
            run_cmd(1'($urandom), 2'($urandom), 12'($urandom),
                    $urandom_range(0, 25), 1'b1, 1'b0, 0);

        run_cmd(1'b0, 2'b01, 12'h3C7, 0, 1'b0, 1'b1, T_SETUP + 1);
        run_cmd(1'b0, 2'b11, 12'h81E, 0, 1'b1, 1'b0, 0);
        run_cmd(1'b1, 2'b00, 12'h000, 3, 1'b1, 1'b1, T_SETUP + 2);
        run_cmd(1'b1, 2'b01, 12'h000, 12, 1'b1, 1'b0, 0);

`ifdef AD574_STS_TIMEOUT_EN
        run_cmd(1'b1, 2'b10, 12'h000, 1000, 1'b0, 1'b0, 0);
        run_cmd(1'b0, 2'b00, 12'h5A5, 0, 1'b0, 1'b0, 0);
        run_cmd(1'b0, 2'b01, 12'h777, 0, 1'b0, 1'b1, T_SETUP);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
